// File: rtl/fp8_pkg.sv
// Shared types and constants for the fp8 operand loader: FSM states and fp8 field layout.
package fp8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PACK  = 2'd2,
    ST_HOLD  = 2'd3
  } ld_state_e;

  localparam int FP8_EXP_W  = 3;
  localparam int FP8_FRAC_W = 4;
  localparam int FP8_BIAS   = 3;

  // A 4.4 magnitude whose top bit is set is 1.x * 2^3, hence exponent field BIAS+3 at L=0.
  localparam logic [FP8_EXP_W-1:0] FP8_EXP_TOP = FP8_EXP_W'(FP8_BIAS + 3);

  localparam logic [7:0] FP8_UFLOW = 8'h00;

endpackage

// File: rtl/fp8_pack.sv
// Combinational fp8 packer: builds {s, e, f} from a normalized magnitude and shift count.
// FP8_LOAD_ROUND_EN adds round-to-nearest (ties up) on guard bit mag[2].
module fp8_pack
  import fp8_pkg::*;
(
  input  logic       sign,
  input  logic [2:0] shift_cnt,
  input  logic [7:0] mag,
  input  logic       uflow,
  output logic [7:0] result
);

  logic [FP8_EXP_W-1:0]  exp_t;
  logic [FP8_FRAC_W-1:0] frac_t;
  logic                  unused_bits;

`ifdef FP8_LOAD_ROUND_EN
  logic [FP8_FRAC_W:0]   frac_r;
  assign unused_bits = ^{mag[7], mag[1:0]};
`else
  assign unused_bits = ^{mag[7], mag[2:0]};
`endif

  always_comb begin
    exp_t  = FP8_EXP_TOP - shift_cnt;
    frac_t = mag[6:3];
    result = {sign, exp_t, frac_t};
`ifdef FP8_LOAD_ROUND_EN
    frac_r = {1'b0, frac_t} + {{FP8_FRAC_W{1'b0}}, mag[2]};
    // Fraction carry-out renormalizes; exponent peaks at 7 so it cannot wrap.
    if (frac_r[FP8_FRAC_W])
      result = {sign, exp_t + 3'd1, {FP8_FRAC_W{1'b0}}};
    else
      result = {sign, exp_t, frac_r[FP8_FRAC_W-1:0]};
`endif
    if (uflow)
      result = FP8_UFLOW;
  end

endmodule

// File: rtl/fp8_operand_loader.sv
// Loads two signed 4.4 magnitudes, normalizes each one shift per cycle into fp8 and
// presents them as op1/op2. Optional rounding via FP8_LOAD_ROUND_EN (see fp8_pack).
module fp8_operand_loader
  import fp8_pkg::*;
#(
  parameter int SHIFT_MAX = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sign,
  input  logic [7:0] in_mag,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [7:0] op1,
  output logic [7:0] op2,
  output logic       uflow
);

  localparam logic [2:0] SHIFT_LIM = 3'(SHIFT_MAX);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // op1/op2/uflow stay stable while op_valid && !op_ready.
  ld_state_e  state;
  logic       slot;
  logic       sign_r;
  logic [7:0] mag_r;
  logic [2:0] shift_cnt;
  logic       uf_r;
  logic [7:0] pack_res;

  fp8_pack u_pack (
    .sign      (sign_r),
    .shift_cnt (shift_cnt),
    .mag       (mag_r),
    .uflow     (uf_r),
    .result    (pack_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      slot      <= 1'b0;
      sign_r    <= 1'b0;
      mag_r     <= 8'h00;
      shift_cnt <= 3'd0;
      uf_r      <= 1'b0;
      op1       <= 8'h00;
      op2       <= 8'h00;
      uflow     <= 1'b0;
      op_valid  <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            sign_r    <= in_sign;
            mag_r     <= in_mag;
            shift_cnt <= 3'd0;
            uf_r      <= 1'b0;
            in_ready  <= 1'b0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (mag_r[7]) begin
            state <= ST_PACK;
          end else if (shift_cnt == SHIFT_LIM) begin
            uf_r  <= 1'b1;
            state <= ST_PACK;
          end else begin
            mag_r     <= {mag_r[6:0], 1'b0};
            shift_cnt <= shift_cnt + 3'd1;
          end
        end
        ST_PACK: begin
          uflow <= uflow | uf_r;
          if (!slot) begin
            op1      <= pack_res;
            slot     <= 1'b1;
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            op2      <= pack_res;
            slot     <= 1'b0;
            op_valid <= 1'b1;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (op_ready) begin
            uflow    <= 1'b0;
            op_valid <= 1'b0;
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
